// File: rtl/div_arb_pkg.sv
// Shared definitions for the two-requester divider arbiter.
package div_arb_pkg;

  // Operand and result widths of the shared divider.
  localparam int DD_W  = 32;
  localparam int DV_W  = 16;
  localparam int Q_W   = 16;
  localparam int CNT_W = 8;

  // Default number of cycles a handshake phase may take before giving up.
  localparam logic [CNT_W-1:0] TMO_LIM_DEF = 8'd255;

  // Arbiter control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/div_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt,
  output logic any
);

  // Tie goes to the opposite of the last grant; otherwise the lone requester.
  always_comb begin
    any = req0 | req1;
    gnt = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one external divider between two requesters using a four-phase
// go/done handshake, with a per-phase watchdog that locks up on a dead divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] TMO_LIM = TMO_LIM_DEF
) (
  input  logic            reloj,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic [DD_W-1:0] dd0,
  input  logic [DD_W-1:0] dd1,
  input  logic [DV_W-1:0] dv0,
  input  logic [DV_W-1:0] dv1,
  output logic            ack0,
  output logic            ack1,
  output logic [Q_W-1:0]  q_out,
  output logic            dz,
  output logic            tmo,
  output logic [DD_W-1:0] div_dd,
  output logic [DV_W-1:0] div_dv,
  output logic            div_go,
  input  logic            div_done,
  input  logic [Q_W-1:0]  div_q
);

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DD_W-1:0]    div_dd_q, div_dd_d;
  logic [DV_W-1:0]    div_dv_q, div_dv_d;
  logic               div_go_q, div_go_d;
  logic [Q_W-1:0]     q_q, q_d;
  logic               dz_q, dz_d;
  logic               tmo_q, tmo_d;

  logic               pick_gnt;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt_inc;

  rr_pick2 u_pick (
    .req0 (req0),
    .req1 (req1),
    .last (last_q),
    .gnt  (pick_gnt),
    .any  (pick_any)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and datapath decisions; every register holds unless changed.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    div_dd_d = div_dd_q;
    div_dv_d = div_dv_q;
    div_go_d = div_go_q;
    q_d      = q_q;
    dz_d     = dz_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d    = pick_gnt;
          div_dd_d = pick_gnt ? dd1 : dd0;
          div_dv_d = pick_gnt ? dv1 : dv0;
          cnt_d    = '0;
          div_go_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Divider acknowledges the start by dropping done.
        if (!div_done) begin
          div_go_d = 1'b0;
          cnt_d    = '0;
          state_d  = WAIT;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_LIM) begin
            tmo_d    = 1'b1;
            div_go_d = 1'b0;
            state_d  = ERR;
          end
        end
      end
      WAIT: begin
        // Result is ready once done returns high.
        if (div_done) begin
          q_d     = div_q;
          dz_d    = (div_dv_q == '0);
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO_LIM) begin
            tmo_d    = 1'b1;
            div_go_d = 1'b0;
            state_d  = ERR;
          end
        end
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      ERR: begin
        div_go_d = 1'b0;
        state_d  = ERR;
      end
      default: begin
        state_d  = IDLE;
        div_go_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, clocked on the falling edge of reloj.
  always_ff @(negedge reloj or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      div_dd_q <= '0;
      div_dv_q <= '0;
      div_go_q <= 1'b0;
      q_q      <= '0;
      dz_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      div_dd_q <= div_dd_d;
      div_dv_q <= div_dv_d;
      div_go_q <= div_go_d;
      q_q      <= q_d;
      dz_q     <= dz_d;
      tmo_q    <= tmo_d;
    end
  end

  // Acks are decoded from the response state so only one can ever be high.
  always_comb begin
    ack0 = (state_q == RESP) && !gnt_q;
    ack1 = (state_q == RESP) &&  gnt_q;
  end

  assign q_out  = q_q;
  assign dz     = dz_q;
  assign tmo    = tmo_q;
  assign div_dd = div_dd_q;
  assign div_dv = div_dv_q;
  assign div_go = div_go_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider on the far side of the handshake,
// directed scenarios plus randomized request batches against a grant-order model.
module tb_div_arbiter;

  localparam logic [7:0] TMO = 8'd255;

  logic        reloj = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] dd0 = '0, dd1 = '0;
  logic [15:0] dv0 = '0, dv1 = '0;
  logic        ack0, ack1, dz, tmo, div_go;
  logic [15:0] q_out, div_dv, div_q;
  logic [31:0] div_dd;
  logic        div_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit last_g   = 1'b1;
  bit stuck    = 1'b0;
  bit dv_busy;
  int dv_lat;

  div_arbiter #(.TMO_LIM(TMO)) dut (
    .reloj    (reloj),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .dd0      (dd0),
    .dd1      (dd1),
    .dv0      (dv0),
    .dv1      (dv1),
    .ack0     (ack0),
    .ack1     (ack1),
    .q_out    (q_out),
    .dz       (dz),
    .tmo      (tmo),
    .div_dd   (div_dd),
    .div_dv   (div_dv),
    .div_go   (div_go),
    .div_done (div_done),
    .div_q    (div_q)
  );

  always #5 reloj = ~reloj;

  // Signed truncating division, 0 on a zero divisor, result cut to 16 bits.
  function automatic logic [15:0] ref_div(logic [31:0] a, logic [15:0] b);
    int sa, sb;
    logic signed [15:0] b_s;
    if (b == 16'd0) return 16'd0;
    b_s = b;
    sa  = a;
    sb  = b_s;
    return 16'(sa / sb);
  endfunction

  // Divider: done idles high, drops on go, returns high after a random
  // latency once go has been released. In stuck mode done never drops.
  always @(negedge reloj or negedge reset) begin
    if (!reset) begin
      div_done <= 1'b1;
      div_q    <= '0;
      dv_busy  <= 1'b0;
      dv_lat   <= 0;
    end else if (stuck) begin
      div_done <= 1'b1;
    end else if (!dv_busy && div_done && div_go) begin
      div_done <= 1'b0;
      dv_busy  <= 1'b1;
      dv_lat   <= $urandom_range(1, 6);
      div_q    <= ref_div(div_dd, div_dv);
    end else if (dv_busy) begin
      if (dv_lat > 0) dv_lat <= dv_lat - 1;
      else if (!div_go) begin
        div_done <= 1'b1;
        dv_busy  <= 1'b0;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply reset right now and check every output sits at its reset value.
  task automatic do_reset();
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #1;
    chk("rst_ack0",   ack0,   0);
    chk("rst_ack1",   ack1,   0);
    chk("rst_div_go", div_go, 0);
    chk("rst_div_dd", div_dd, 0);
    chk("rst_div_dv", div_dv, 0);
    chk("rst_q_out",  q_out,  0);
    chk("rst_dz",     dz,     0);
    chk("rst_tmo",    tmo,    0);
    repeat (2) @(posedge reloj);
    reset  = 1'b1;
    last_g = 1'b1;
    @(posedge reloj);
  endtask

  // Wait for one ack and check its requester and payload.
  // drop: 0 keep requests, 1 drop the served one, 2 drop both.
  task automatic expect_ack(bit id, logic [31:0] dd, logic [15:0] dv,
                            logic [15:0] q_exp, bit dz_exp, int drop);
    bit got = 1'b0;
    bit who = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge reloj);
      if (ack0 || ack1) begin
        got = 1'b1;
        who = ack1;
        break;
      end
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    chk("ack_both", 32'(ack0 && ack1), 0);
    chk("ack_id",   32'(who), 32'(id));
    chk("q_out",    q_out, q_exp);
    chk("dz",       dz, dz_exp);
    chk("div_dd",   div_dd, dd);
    chk("div_dv",   div_dv, dv);
    $display("ack%0d dd=%0d dv=%0d q_out=%0d dz=%0d (expected ack%0d q=%0d dz=%0d)",
             who, $signed(div_dd), $signed(div_dv), $signed(q_out), dz,
             id, $signed(q_exp), dz_exp);
    if (drop == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end else if (drop == 1) begin
      if (who) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    last_g = id;
    @(posedge reloj);
    chk("ack_pulse", 32'({ack0, ack1}), 0);
  endtask

  // Raise a set of requests together and expect them served in round-robin order.
  task automatic run_batch(bit m0, bit m1, logic [31:0] a0, logic [15:0] b0,
                           logic [31:0] a1, logic [15:0] b1);
    bit first;
    first = (m0 && m1) ? !last_g : m1;
    dd0 = a0; dv0 = b0; dd1 = a1; dv1 = b1;
    req0 = m0; req1 = m1;
    if (first) expect_ack(1'b1, a1, b1, ref_div(a1, b1), b1 == 0, 1);
    else       expect_ack(1'b0, a0, b0, ref_div(a0, b0), b0 == 0, 1);
    if (m0 && m1) begin
      if (first) expect_ack(1'b0, a0, b0, ref_div(a0, b0), b0 == 0, 1);
      else       expect_ack(1'b1, a1, b1, ref_div(a1, b1), b1 == 0, 1);
    end
  endtask

  function automatic logic [31:0] rnd_dd();
    return 32'($urandom_range(0, 2097152)) - 32'd1048576;
  endfunction

  function automatic logic [15:0] rnd_dv();
    if ($urandom_range(0, 7) == 0) return 16'd0;
    return 16'($urandom);
  endfunction

  initial begin
    int n;
    int acks;
    int r;
    bit ok;

    do_reset();

    // Single requester, real divider.
    dd0 = 32'd100; dv0 = 16'd7; req0 = 1'b1;
    expect_ack(1'b0, 32'd100, 16'd7, 16'd14, 1'b0, 1);

    // Simultaneous requests right after reset: requester 0 first.
    do_reset();
    dd0 = -32'sd50; dv0 = 16'd5; dd1 = 32'd81; dv1 = 16'd9;
    req0 = 1'b1; req1 = 1'b1;
    expect_ack(1'b0, -32'sd50, 16'd5, -16'sd10, 1'b0, 1);
    expect_ack(1'b1, 32'd81, 16'd9, 16'd9, 1'b0, 1);

    // Divide by zero.
    dd1 = 32'd1234; dv1 = 16'd0; req1 = 1'b1;
    expect_ack(1'b1, 32'd1234, 16'd0, 16'd0, 1'b1, 1);

    // Both held continuously: grants alternate 0,1,0,1.
    dd0 = 32'd1000; dv0 = 16'd10; dd1 = 32'd77; dv1 = 16'd7;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_ack(1'b0, 32'd1000, 16'd10, 16'd100, 1'b0, (k == 3) ? 2 : 0);
      else            expect_ack(1'b1, 32'd77, 16'd7, 16'd11, 1'b0, (k == 3) ? 2 : 0);
    end

    // Randomized batches.
    for (int b = 0; b < 40; b++) begin
      r = $urandom_range(1, 3);
      run_batch(r[0], r[1], rnd_dd(), rnd_dv(), rnd_dd(), rnd_dv());
      repeat ($urandom_range(0, 3)) @(posedge reloj);
    end

    // Reset while waiting for the divider result.
    dd0 = 32'd500; dv0 = 16'd4; req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge reloj);
      if (div_go) begin ok = 1'b1; break; end
    end
    chk("go_rise", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge reloj);
      if (!div_go) begin ok = 1'b1; break; end
    end
    chk("go_fall", 32'(ok), 1);
    do_reset();
    dd0 = 32'd9; dv0 = 16'd3; req0 = 1'b1;
    expect_ack(1'b0, 32'd9, 16'd3, 16'd3, 1'b0, 1);

    // Dead divider: done never drops, watchdog must trip and lock up.
    stuck = 1'b1;
    dd0 = 32'd5; dv0 = 16'd1; req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge reloj);
      if (div_go) begin ok = 1'b1; break; end
    end
    chk("tmo_go_rise", 32'(ok), 1);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge reloj);
      n++;
      if (tmo) break;
    end
    chk("tmo_set", tmo, 1);
    chk("tmo_latency", 32'((n >= TMO) && (n <= TMO + 1)), 1);
    chk("tmo_go_low", div_go, 0);
    $display("timeout after %0d cycles, tmo=%0d div_go=%0d", n, tmo, div_go);
    req0 = 1'b1; req1 = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge reloj);
      if (ack0 || ack1 || div_go) acks++;
    end
    chk("err_no_acks", acks, 0);
    chk("err_tmo_sticky", tmo, 1);
    stuck = 1'b0;
    do_reset();
    dd0 = 32'd42; dv0 = 16'd6; req0 = 1'b1;
    expect_ack(1'b0, 32'd42, 16'd6, 16'd7, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

endmodule
